light_pattern_gen: RTL and testbench

LIGHT_PATTERN_GEN -- requirements
Module: light_pattern_gen

---
 rtl/light_pattern_gen_pkg.sv | 18 +
 rtl/light_pattern_gen_lfsr16.sv | 32 +++
 rtl/light_pattern_gen.sv | 122 ++++++++++++
 tb/tb_light_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pattern_gen_pkg.sv
// Shared definitions for the light pattern generator: FSM encoding, LFSR taps
// and pattern sizing constants.
package light_pattern_gen_pkg;

    localparam int PATTERN_W = 16;
    localparam int MAX_RETRY = 15;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_BUILD,
        ST_PUBLISH,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/light_pattern_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with zero detection and seed reload;
// exposes only the low nibble used as a candidate bit index.
module lfsr16
    import light_pattern_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [3:0] o_idx
);

    logic [15:0] r_lfsr;
    logic        w_feedback;
    logic        w_isZero;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);
    assign w_isZero   = (r_lfsr == 16'h0000);
    assign o_idx      = r_lfsr[3:0];

    // An all-zero state would lock the register, so it is replaced by the seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else if (w_isZero) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

endmodule

// File: rtl/light_pattern_gen.sv
// Builds random light patterns with select+1 distinct lit positions, publishes
// them to the game FSM and holds them frozen while random_enable is low.
module light_pattern_gen
    import light_pattern_gen_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 random_enable,
    input  logic                 lights_off,
    input  logic [1:0]           select,
    output logic [PATTERN_W-1:0] light_pattern,
    output logic                 pattern_ready,
    output logic [2:0]           lit_count
);

    logic [1:0]           r_rstSync;
    logic                 w_rstN;
    logic [3:0]           w_idx;
    logic [3:0]           w_lowFree;
    state_t               r_state;
    logic [PATTERN_W-1:0] r_work;
    logic [PATTERN_W-1:0] r_patQ;
    logic [2:0]           r_placed;
    logic [2:0]           r_target;
    logic [3:0]           r_retry;
    logic [2:0]           r_litCount;
    logic                 r_ready;

    // Assertion passes straight through; release is delayed two clocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetn (w_rstN),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_lowFree = 4'd0;
        for (int i = PATTERN_W - 1; i >= 0; i--) begin
            if (!r_work[i]) begin
                w_lowFree = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state    <= ST_CLEAR;
            r_work     <= '0;
            r_patQ     <= '0;
            r_placed   <= 3'd0;
            r_target   <= 3'd0;
            r_retry    <= 4'd0;
            r_litCount <= 3'd0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_work   <= '0;
                    r_placed <= 3'd0;
                    r_retry  <= 4'd0;
                    r_target <= {1'b0, select} + 3'd1;
                    r_state  <= ST_BUILD;
                end
                ST_BUILD: begin
                    // After a run of collisions the lowest free slot guarantees progress.
                    if (r_placed == r_target) begin
                        r_state <= ST_PUBLISH;
                    end else if (r_retry == 4'(MAX_RETRY)) begin
                        r_work[w_lowFree] <= 1'b1;
                        r_placed          <= r_placed + 3'd1;
                        r_retry           <= 4'd0;
                    end else if (!r_work[w_idx]) begin
                        r_work[w_idx] <= 1'b1;
                        r_placed      <= r_placed + 3'd1;
                        r_retry       <= 4'd0;
                    end else begin
                        r_retry <= r_retry + 4'd1;
                    end
                end
                ST_PUBLISH: begin
                    r_patQ     <= r_work;
                    r_litCount <= r_target;
                    if (random_enable) begin
                        r_state <= ST_CLEAR;
                    end else begin
                        r_state <= ST_HOLD;
                        r_ready <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (random_enable) begin
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign light_pattern = lights_off ? '0 : r_patQ;
    assign pattern_ready = r_ready;
    assign lit_count     = r_litCount;

endmodule

// File: tb/tb_light_pattern_gen.sv
// Self-checking bench for light_pattern_gen: reference build model feeding a
// scoreboard, a table of HOLD-state vectors and hand-written corner sequences.
module tb_light_pattern_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [15:0] pat;
        logic        checkPat;
        logic [2:0]  cnt;
    } exp_t;

    typedef struct {
        logic       lightsOff;
        logic [1:0] sel;
        logic       expShow;
        logic       expReady;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        random_enable;
    logic        lights_off;
    logic [1:0]  select;
    logic [15:0] light_pattern;
    logic        pattern_ready;
    logic [2:0]  lit_count;

    int   assertCount = 0;
    int   failCount   = 0;
    exp_t sbQueue[$];
    vec_t vectors[6];

    light_pattern_gen #(
        .LFSR_SEED (SEED)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .random_enable (random_enable),
        .lights_off    (lights_off),
        .select        (select),
        .light_pattern (light_pattern),
        .pattern_ready (pattern_ready),
        .lit_count     (lit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference build starting from the LFSR value seen in the CLEAR cycle.
    function automatic logic [15:0] modelBuild(input logic [15:0] lfsrAtClear, input int target);
        logic [15:0] work;
        logic [15:0] l;
        logic [3:0]  idx;
        int          placed;
        int          retry;
        work   = 16'h0000;
        l      = lfsrAtClear;
        placed = 0;
        retry  = 0;
        for (int c = 0; c < 200; c++) begin
            l = lfsrStep(l);
            if (placed == target) break;
            idx = l[3:0];
            if (retry == 15) begin
                for (int i = 0; i < 16; i++) begin
                    if (!work[i]) begin
                        work[i] = 1'b1;
                        break;
                    end
                end
                placed++;
                retry = 0;
            end else if (!work[idx]) begin
                work[idx] = 1'b1;
                placed++;
                retry = 0;
            end else begin
                retry++;
            end
        end
        return work;
    endfunction

    task automatic applyStimulus(input logic re, input logic lo, input logic [1:0] sel);
        random_enable = re;
        lights_off    = lo;
        select        = sel;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [15:0] pat, input logic checkPat, input logic [2:0] cnt);
        exp_t e;
        e.pat      = pat;
        e.checkPat = checkPat;
        e.cnt      = cnt;
        sbQueue.push_back(e);
    endtask

    task automatic pulseEnable(input logic [1:0] sel);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, sel);
        @(negedge clk);
        random_enable = 1'b0;
    endtask

    task automatic popAndCheck(input string name, input int maxCycles, output logic [15:0] expPat);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (pattern_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_ready"}, 32'(seen), 32'd1);
        if (sbQueue.size() == 0) begin
            failCount++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", name);
            expPat = 16'h0000;
        end else begin
            e = sbQueue.pop_front();
            expPat = e.pat;
            checkOutput({name, "_lit_count"}, 32'(lit_count), 32'(e.cnt));
            checkOutput({name, "_popcount"}, 32'($countones(light_pattern)), 32'(e.cnt));
            if (e.checkPat) checkOutput({name, "_pattern"}, 32'(light_pattern), 32'(e.pat));
        end
    endtask

    initial begin
        logic [15:0] heldPat;
        logic [15:0] firstPat;
        logic [15:0] stablePat;
        bit          sawReady;
        int          changes;

        vectors[0] = '{lightsOff: 1'b1, sel: 2'b00, expShow: 1'b0, expReady: 1'b1};
        vectors[1] = '{lightsOff: 1'b0, sel: 2'b00, expShow: 1'b1, expReady: 1'b1};
        vectors[2] = '{lightsOff: 1'b0, sel: 2'b11, expShow: 1'b1, expReady: 1'b1};
        vectors[3] = '{lightsOff: 1'b1, sel: 2'b10, expShow: 1'b0, expReady: 1'b1};
        vectors[4] = '{lightsOff: 1'b1, sel: 2'b01, expShow: 1'b0, expReady: 1'b1};
        vectors[5] = '{lightsOff: 1'b0, sel: 2'b01, expShow: 1'b1, expReady: 1'b1};

        $display("[TB] Starting light_pattern_gen test");
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("reset_pattern", 32'(light_pattern), 32'h0);
        checkOutput("reset_ready", 32'(pattern_ready), 32'h0);
        checkOutput("reset_lit_count", 32'(lit_count), 32'h0);

        pushExpect(modelBuild(SEED, 1), 1'b1, 3'd1);
        resetn = 1'b1;
        popAndCheck("first_build", 100, firstPat);
        repeat (5) @(negedge clk);
        checkOutput("first_hold_ready", 32'(pattern_ready), 32'd1);
        checkOutput("first_hold_pattern", 32'(light_pattern), 32'(firstPat));

        // Pattern must follow lights_off in the same cycle and ignore select in HOLD.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b0, vectors[v].lightsOff, vectors[v].sel);
            #1;
            checkOutput($sformatf("hold_vec%0d_pattern", v), 32'(light_pattern),
                        32'(vectors[v].expShow ? firstPat : 16'h0000));
            checkOutput($sformatf("hold_vec%0d_ready", v), 32'(pattern_ready), 32'(vectors[v].expReady));
            @(negedge clk);
            checkOutput($sformatf("hold_vec%0d_lit", v), 32'(lit_count), 32'd1);
        end

        applyStimulus(1'b1, 1'b0, 2'b10);
        sawReady = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pattern_ready) sawReady = 1'b1;
        end
        checkOutput("regen_ready_low", 32'(sawReady), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b10);
        pushExpect(16'h0000, 1'b0, 3'd3);
        popAndCheck("enable_drop", 100, heldPat);

        pulseEnable(2'b00);
        @(negedge clk);
        select = 2'b11;
        pushExpect(16'h0000, 1'b0, 3'd1);
        popAndCheck("select_change_mid_build", 100, heldPat);

        pulseEnable(2'b11);
        pushExpect(16'h0000, 1'b0, 3'd4);
        popAndCheck("select3_build", 70, heldPat);
        stablePat = light_pattern;
        changes = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (light_pattern !== stablePat || !pattern_ready) changes++;
        end
        checkOutput("hold_stable_1000", 32'(changes), 32'd0);

        pulseEnable(2'b11);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset_pattern", 32'(light_pattern), 32'h0);
        checkOutput("async_reset_ready", 32'(pattern_ready), 32'h0);
        checkOutput("async_reset_lit", 32'(lit_count), 32'h0);
        @(negedge clk);
        pushExpect(modelBuild(SEED, 4), 1'b1, 3'd4);
        resetn = 1'b1;
        popAndCheck("post_reset_build", 150, heldPat);

        force dut.w_idx = 4'd0;
        pulseEnable(2'b01);
        pushExpect(16'h0003, 1'b1, 3'd2);
        popAndCheck("retry_idx0", 100, heldPat);

        force dut.w_idx = 4'd5;
        pulseEnable(2'b10);
        pushExpect(16'h0023, 1'b1, 3'd3);
        popAndCheck("retry_idx5", 120, heldPat);
        release dut.w_idx;

        pulseEnable(2'b01);
        pushExpect(16'h0000, 1'b0, 3'd2);
        popAndCheck("after_release", 100, heldPat);

        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
